// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the RISC-V multicycle core: sequences PC, IR, memory,
// ALU and register file. Ports: clk, reset (sync, active-high), op, Zero in;
// PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
// RegWrite, Illegal, state_o out. STATE_W >= 4; upper bits of state_o are 0.
// Optional: `define ILLEGAL_OP_TRAP_EN sends unknown opcodes to a sticky TRAP.
module multicycle_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               RegWrite,
  output logic               Illegal,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t state_q, state_d;

  logic pc_update;
  logic branch;
  logic mem_write;
  logic ir_write;
  logic reg_write;
  logic known_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    known_op = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R,
      OP_I, OP_JAL, OP_BEQ: known_op = 1'b1;
      default:              known_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_d = S_TRAP;
`else
          // unknown opcode retires as a 2-cycle NOP
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_d = S_MEMREAD;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`else
      S_TRAP:     state_d = S_FETCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        // OldPC + imm: branch target ready for BEQ
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_JAL: begin
        // OldPC + 4 is the link value; target came from DECODE
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // reset aborts the current instruction: no enable may fire on that edge
  assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign IRWrite  = ir_write & ~reset;
  assign RegWrite = reg_write & ~reset;

  assign state_o = STATE_W'(state_q);

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (state_q == S_DECODE && !known_op) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign Illegal = illegal_q;
`else
  logic unused_known;
  assign unused_known = known_op;
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: table of per-cycle vectors
// through a scoreboard queue, plus reset, trap and mid-instruction abort.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic [6:0] op;
    logic       z;
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] aop;
    logic       rw;
    logic       ill;
  } vec_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state_o;

  int checks = 0;
  int failures = 0;

  vec_t tbl[$];
  vec_t sb[$];

  multicycle_ctrl_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite),
    .Illegal(Illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t v(input logic [6:0] o, input logic z,
    input logic [3:0] st, input logic pcw, input logic adr,
    input logic mw, input logic irw, input logic [1:0] rs,
    input logic [1:0] sa, input logic [1:0] sb_, input logic [1:0] aop,
    input logic rw, input logic ill);
    vec_t r;
    r = '{o, z, st, pcw, adr, mw, irw, rs, sa, sb_, aop, rw, ill};
    return r;
  endfunction

  function automatic vec_t sample(input vec_t e);
    vec_t r;
    r = '{e.op, e.z, state_o, PCWrite, AdrSrc, MemWrite, IRWrite,
          ResultSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite, Illegal};
    return r;
  endfunction

  // row: op, Zero, state, pcw adr mw irw, rs sa sb aop, rw ill
  // op in non-sampling states is junk on purpose
  task automatic fill;
    // fetch (always the same outputs) with junk op
    // lw
    tbl.push_back(v(BAD, 0, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0));
    tbl.push_back(v(LW,  0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(LW,  0, 2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(v(RT,  0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(BAD, 0, 4, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    // sw
    tbl.push_back(v(LW,  0, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0));
    tbl.push_back(v(SW,  0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(SW,  0, 2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(v(LW,  0, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    // beq taken
    tbl.push_back(v(BQ,  1, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0));
    tbl.push_back(v(BQ,  1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(BAD, 1, 10, 1, 0, 0, 0, 0, 2, 0, 1, 0, 0));
    // beq not taken
    tbl.push_back(v(BQ,  0, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0));
    tbl.push_back(v(BQ,  0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(BQ,  0, 10, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0));
    // jal
    tbl.push_back(v(JL,  0, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0));
    tbl.push_back(v(JL,  0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(BAD, 1, 9, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(v(BAD, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // R-type
    tbl.push_back(v(RT,  0, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0));
    tbl.push_back(v(RT,  0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(LW,  1, 6, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
    tbl.push_back(v(RT,  0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // I-type
    tbl.push_back(v(IT,  0, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0));
    tbl.push_back(v(IT,  0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(SW,  0, 8, 0, 0, 0, 0, 0, 2, 1, 2, 0, 0));
    tbl.push_back(v(IT,  0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // unknown opcode
    tbl.push_back(v(BAD, 0, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0));
    tbl.push_back(v(BAD, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
`ifdef ILLEGAL_OP_TRAP_EN
    tbl.push_back(v(LW,  1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`else
    tbl.push_back(v(LW,  0, 0, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0));
    tbl.push_back(v(LW,  0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
`endif
  endtask

  initial begin
    vec_t e, a;
    reset = 1'b1;
    op    = 7'd0;
    Zero  = 1'b0;
    fill();

    // two cycles of reset
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_state", 32'(state_o), 0);
      chk("rst_pcw", 32'(PCWrite), 0);
      chk("rst_irw", 32'(IRWrite), 0);
      chk("rst_ill", 32'(Illegal), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_pcw", 32'(PCWrite), 1);
    chk("rel_irw", 32'(IRWrite), 1);
    chk("rel_state", 32'(state_o), 0);

    foreach (tbl[i]) begin
      op   = tbl[i].op;
      Zero = tbl[i].z;
      sb.push_back(tbl[i]);
      #1;
      e = sb.pop_front();
      a = sample(e);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL vec%0d st=%0d got=%h exp=%h", i, e.st, a, e);
      end
      @(negedge clk);
    end

`ifdef ILLEGAL_OP_TRAP_EN
    // trap is absorbing regardless of op
    for (int i = 0; i < 10; i++) begin
      op = (i % 2 == 0) ? LW : RT;
      #1;
      chk("trap_state", 32'(state_o), 11);
      chk("trap_ill", 32'(Illegal), 1);
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("trap_clr_state", 32'(state_o), 0);
    chk("trap_clr_ill", 32'(Illegal), 0);
    reset = 1'b0;
    #1;
    chk("trap_rel_irw", 32'(IRWrite), 1);
    @(negedge clk);
`else
    chk("nop_ill", 32'(Illegal), 0);
    chk("nop_state", 32'(state_o), 2);
    // finish the pending lw so the next sequence starts in FETCH
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("nop_done", 32'(state_o), 0);
`endif

    // reset in MEMWB aborts the register write
    op = LW;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("abort_pre_st", 32'(state_o), 4);
    chk("abort_pre_rw", 32'(RegWrite), 1);
    reset = 1'b1;
    #1;
    chk("abort_rw", 32'(RegWrite), 0);
    chk("abort_st", 32'(state_o), 4);
    @(negedge clk);
    chk("abort_next", 32'(state_o), 0);
    chk("abort_pcw", 32'(PCWrite), 0);
    reset = 1'b0;
    #1;
    chk("abort_rel_pcw", 32'(PCWrite), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control state machine for the RISC-V multicycle processor. It sequences the shared datapath: one memory port, one ALU, the register file, IR and PC.
- Takes the opcode from the instruction register and the ALU Zero flag.
- Produces per-cycle mux selects, write enables and ALUOp.
- Sits in the controller beside the immediate-source decoder and the ALU decoder.

Parameters:
- STATE_W, 4, width of the state register; must be ≥4. Upper bits are zero when wider.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op  input  7  opcode field of the instruction register (instr[6:0])
- Zero  input  1  ALU zero flag, valid in the BEQ state
- PCWrite  output  1  PC register enable = PCUpdate | (Branch & Zero)
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register and OldPC enable
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1 register
- ALUSrcB  output  2  00=RD2 register, 01=ImmExt, 10=constant 4
- ALUOp  output  2  00=add, 01=subtract/compare, 10=funct-decoded
- RegWrite  output  1  register file write enable
- Illegal  output  1  sticky illegal-opcode flag (see Optional Feature)
- state_o  output  STATE_W  current state, for debug and verification

Behaviour:
Machine type and reset:
- Moore FSM: all outputs are a function of the state register only, except PCWrite, which also uses Zero.
- Synchronous reset: on the clk edge with reset=1, state <= FETCH and Illegal <= 0.
- While reset=1, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0. Selects show FETCH values.

Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, TRAP=11. Unused codes go to FETCH on the next edge.

Output defaults: every output not listed for a state is 0 (selects 00), never X.

State outputs:
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Precomputes the branch target.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- TRAP: all enables 0.

Transitions:
- FETCH→DECODE.
- DECODE, by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other opcode → see Optional Feature
- MEMADR: op=0000011 → MEMREAD; otherwise → MEMWRITE.
- MEMREAD→MEMWB→FETCH.
- MEMWRITE→FETCH.
- EXECUTER, EXECUTEI and JAL → ALUWB; ALUWB→FETCH.
- BEQ→FETCH.

Latency in cycles: lw 5; sw 4; R-type, I-type and jal 4; beq 3.

Boundaries:
- op is sampled only in DECODE and MEMADR. Changes in other states are ignored.
- Reset asserted mid-instruction aborts it: no write enable fires on that edge, and the next state is FETCH.
- BEQ with Zero=1 gives PCWrite=1; with Zero=0, PCWrite=0.

Optional Feature:
Macro ILLEGAL_OP_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP and sets Illegal=1. TRAP is absorbing and Illegal stays 1 until reset.
- Undefined: an unknown opcode in DECODE goes to FETCH, so the instruction executes as a 2-cycle NOP. The TRAP state is unreachable and Illegal is tied to 0.

Test Plan:
- Reset for 2 cycles, then release → state_o=0; PCWrite and IRWrite are 0 during reset and 1 in the first cycle after release.
- op=0000011 after reset → state_o sequence 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; AdrSrc=1 only in state 3.
- op=0100011 → sequence 0,1,2,5,0; MemWrite=1 for exactly one cycle; RegWrite never asserted.
- op=1100011 with Zero=1, then again with Zero=0 → sequence 0,1,10,0; PCWrite=1 in state 10 only when Zero=1; ALUOp=01 in state 10.
- op=1101111, then op=0110011 → sequences 0,1,9,7,0 and 0,1,6,7,0; in state 9 PCWrite=1 and ALUSrcA=01, ALUSrcB=10.
- op=1111111 → with ILLEGAL_OP_TRAP_EN: state_o=11 and Illegal=1 held for 10 cycles, cleared by reset. Without the macro: sequence 0,1,0 and Illegal=0.
